// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup, resolve-update and statistics bus of the direct-mapped BTB.
// The master side drives fetch/update/flush; the slave side is the predictor.
interface branch_predictor_btb_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispredict;
  logic            flush;
  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispredicts;

  // upd_* fields are meaningful only in cycles where upd_valid=1; there is no
  // back-pressure, every valid update is consumed at the next rising edge.
  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    input  pred_taken, pred_target, stat_branches, stat_mispredicts
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    output pred_taken, pred_target, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BP_STATS_EN to build the saturating branch/mispredict counters.
module branch_predictor_btb #(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16
) (
  input logic                  CLK,
  input logic                  reset,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_ctr_next;

  assign w_f_idx = bus.fetch_pc[IDX_W-1:0];
  assign w_f_tag = bus.fetch_pc[PC_W-1:IDX_W];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign bus.pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
  assign bus.pred_target = w_f_hit ? r_target[w_f_idx] : '0;

  assign w_u_idx = bus.upd_pc[IDX_W-1:0];
  assign w_u_tag = bus.upd_pc[PC_W-1:IDX_W];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  always_comb begin
    w_ctr_next = r_ctr[w_u_idx];
    if (bus.upd_taken) begin
      if (w_ctr_next != 2'b11) w_ctr_next = w_ctr_next + 2'b01;
    end else begin
      if (w_ctr_next != 2'b00) w_ctr_next = w_ctr_next - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (bus.flush) begin
      // Flush wins over a simultaneous update; counters and targets are kept.
      r_valid <= '0;
    end else if (bus.upd_valid) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_ctr_next;
        if (bus.upd_taken) r_target[w_u_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= bus.upd_target;
        r_ctr[w_u_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_mp;

  // Counting ignores flush; only reset clears the counters.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (bus.upd_valid && (r_stat_br != 16'hFFFF)) r_stat_br <= r_stat_br + 16'd1;
      if (bus.upd_valid && bus.upd_mispredict && (r_stat_mp != 16'hFFFF))
        r_stat_mp <= r_stat_mp + 16'd1;
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mp;
`else
  logic w_unused_mispredict;
  assign w_unused_mispredict  = bus.upd_mispredict;
  assign bus.stat_branches    = 16'h0000;
  assign bus.stat_mispredicts = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed cases plus random traffic checked
// every cycle against a table model; honours BP_STATS_EN like the design.
module tb_branch_predictor_btb;
`ifdef BP_STATS_EN
  localparam bit STATS_EN = 1'b1;
  localparam int STAT_UPDATES = 66000;
`else
  localparam bit STATS_EN = 1'b0;
  localparam int STAT_UPDATES = 300;
`endif

  logic CLK;
  logic reset;
  int   n_cmp;
  int   n_err;

  branch_predictor_btb_if #(.PC_W(8)) bus ();

  branch_predictor_btb #(.PC_W(8), .ENTRIES(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock/reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit         m_valid [16];
  logic [7:0] m_pc    [16];
  logic [7:0] m_tgt   [16];
  int         m_ctr   [16];
  int         m_br;
  int         m_mp;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_pc[i]    = 8'h00;
      m_tgt[i]   = 8'h00;
      m_ctr[i]   = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_lookup(input logic [7:0] pc, output logic t, output logic [7:0] tg);
    int  i;
    bit  hit;
    i   = int'(pc) % 16;
    hit = m_valid[i] && (int'(m_pc[i]) / 16 == int'(pc) / 16);
    t   = hit && (m_ctr[i] >= 2);
    tg  = hit ? m_tgt[i] : 8'h00;
  endfunction

  function automatic void model_update(input bit fl, input bit uv, input logic [7:0] upc,
                                       input bit ut, input logic [7:0] utg, input bit um);
    int i;
    bit hit;
    if (uv) begin
      if (m_br < 65535) m_br++;
      if (um && m_mp < 65535) m_mp++;
    end
    i   = int'(upc) % 16;
    hit = m_valid[i] && (int'(m_pc[i]) / 16 == int'(upc) / 16);
    if (fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      if (hit) begin
        m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ut) m_tgt[i] = utg;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = upc;
        m_tgt[i]   = utg;
        m_ctr[i]   = 2;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       et;
    logic [7:0] eg;
    model_lookup(bus.fetch_pc, et, eg);
    cmp({tag, ".pred_taken"},  32'(bus.pred_taken),  32'(et));
    cmp({tag, ".pred_target"}, 32'(bus.pred_target), 32'(eg));
    cmp({tag, ".stat_branches"},    32'(bus.stat_branches),    STATS_EN ? 32'(m_br) : 32'd0);
    cmp({tag, ".stat_mispredicts"}, 32'(bus.stat_mispredicts), STATS_EN ? 32'(m_mp) : 32'd0);
  endtask

  // Literal expectation pins both the model and the DUT for the current fetch_pc.
  task automatic lit(input string name, input logic et, input logic [7:0] eg);
    logic       mt;
    logic [7:0] mg;
    model_lookup(bus.fetch_pc, mt, mg);
    cmp({name, ".model_taken"}, 32'(mt), 32'(et));
    cmp({name, ".dut_taken"},   32'(bus.pred_taken), 32'(et));
    if (et) begin
      cmp({name, ".model_target"}, 32'(mg), 32'(eg));
      cmp({name, ".dut_target"},   32'(bus.pred_target), 32'(eg));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] fpc, input bit fl, input bit uv, input logic [7:0] upc,
                       input bit ut, input logic [7:0] utg, input bit um);
    bus.fetch_pc       = fpc;
    bus.flush          = fl;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utg;
    bus.upd_mispredict = um;
  endtask

  task automatic sample(input string tag);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic commit();
    @(posedge CLK);
    model_update(bus.flush, bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target,
                 bus.upd_mispredict);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] fpc, input bit fl, input bit uv,
                      input logic [7:0] upc, input bit ut, input logic [7:0] utg, input bit um);
    drive(fpc, fl, uv, upc, ut, utg, um);
    sample(tag);
    commit();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("in_reset");
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(8'h25, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    model_reset();
    #3;
    lit("reset_0x25", 1'b0, 8'h00);
    check_outputs("reset_async");
    do_reset();

    step("idle", 8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("after_reset");
    lit("after_reset_0x25", 1'b0, 8'h00);
    commit();

    // Basic allocation and alias rejection.
    step("alloc_25", 8'h25, 0, 1, 8'h25, 1, 8'h40, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("hit_25");
    lit("hit_25", 1'b1, 8'h40);
    commit();
    drive(8'h35, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("alias_35");
    lit("alias_35", 1'b0, 8'h00);
    commit();

    // Counter walk: 10 -> 01 -> 00, then up to 11 and saturate, then back down.
    step("nt1", 8'h25, 0, 1, 8'h25, 0, 8'h99, 0);
    step("nt2", 8'h25, 0, 1, 8'h25, 0, 8'h99, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("ctr00");
    lit("ctr00", 1'b0, 8'h00);
    commit();
    for (int k = 0; k < 4; k++) step("tk", 8'h25, 0, 1, 8'h25, 1, 8'h40, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("ctr11");
    lit("ctr11", 1'b1, 8'h40);
    commit();
    step("nt_sat", 8'h25, 0, 1, 8'h25, 0, 8'h00, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("ctr10");
    lit("ctr10_from_sat", 1'b1, 8'h40);
    commit();
    step("nt_again", 8'h25, 0, 1, 8'h25, 0, 8'h00, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("ctr01");
    lit("ctr01", 1'b0, 8'h00);
    commit();

    // Same-cycle lookup and first allocation at 0x12.
    drive(8'h12, 0, 1, 8'h12, 1, 8'h77, 0);
    sample("same_cycle");
    lit("same_cycle_pre", 1'b0, 8'h00);
    commit();
    drive(8'h12, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("same_cycle_next");
    lit("same_cycle_post", 1'b1, 8'h77);
    commit();

    // Flush beats a simultaneous taken update.
    step("alloc_25b", 8'h25, 0, 1, 8'h25, 1, 8'h41, 0);
    step("flush_upd", 8'h25, 1, 1, 8'h25, 1, 8'h50, 0);
    drive(8'h25, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("post_flush");
    lit("post_flush_25", 1'b0, 8'h00);
    commit();
    drive(8'h12, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("post_flush12");
    lit("post_flush_12", 1'b0, 8'h00);
    commit();

    // Reset asserted while an update is presented discards it.
    drive(8'h55, 0, 1, 8'h55, 1, 8'h66, 0);
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    @(posedge CLK);
    #2;
    reset = 1'b1;
    drive(8'h55, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("mid_reset");
    lit("mid_reset_55", 1'b0, 8'h00);
    commit();

    // Random traffic over 64 PCs (4 tags per index) to exercise aliasing.
    for (int n = 0; n < 3000; n++) begin
      step("rand", 8'($urandom_range(0, 63)), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 63)),
           ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Statistics: long update run with exactly three mispredicts.
    do_reset();
    for (int n = 0; n < STAT_UPDATES; n++) begin
      step("stat", 8'($urandom), ($urandom_range(0, 99) == 0), 1'b1, 8'($urandom),
           ($urandom_range(0, 1) == 1), 8'($urandom), (n == 10 || n == 200 || n == 250));
    end
    drive(8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    sample("stat_end");
    cmp("stat_branches_final", 32'(bus.stat_branches),
        STATS_EN ? 32'h0000FFFF : 32'h0);
    cmp("stat_mispredicts_final", 32'(bus.stat_mispredicts),
        STATS_EN ? 32'h3 : 32'h0);
    commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
